// File: rtl/pwm_cfg_ctrl.sv
// Duty/enable configuration controller for the triangle PWM: SPI and UART command decode,
// arbitration, shadowed duty commit at period boundary, and UART ACK/NAK generation.
module pwm_cfg_ctrl #(
  parameter int unsigned DUTY_MAX    = 10000,
  parameter int unsigned DUTY_RST    = 5000,
  parameter int unsigned TIMEOUT_CYC = 17300,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] spi_word,
  input  logic        spi_valid,
  input  logic [7:0]  uart_byte,
  input  logic        uart_valid,
  input  logic        period_end,
  input  logic        txd_busy,
  output logic [15:0] pwm_duty,
  output logic        pwm_enable,
  output logic        txd_en,
  output logic [7:0]  txd_data,
  output logic        cfg_err
);

  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned TW = 15;

  typedef enum logic [1:0] {S_IDLE, S_DUTY_HI, S_DUTY_LO, S_ENA} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   hi_q;
  logic [TW-1:0]   tmo_q;
  logic [DW-1:0]   shadow_q;
  logic            shadow_valid_q;
  logic            pend_duty_q, pend_ena_q;
  logic [DW-1:0]   pend_val_q;
  logic            ack_full_q;
  logic [BW-1:0]   ack_byte_q;

  logic            timeout_c;
  logic [DW-1:0]   uart_duty_c;
  logic            u_duty_req_c, u_ena_req_c, u_ack_req_c, u_err_c;
  logic [BW-1:0]   u_ack_byte_c;
  logic            spi_ctrl_c, spi_duty_c, spi_bad_c, spi_req_c, u_defer_c;
  logic            duty_wr_c, ena_wr_c, ena_val_c;
  logic [DW-1:0]   duty_val_c;

  assign timeout_c   = (state_q != S_IDLE) && (tmo_q == TW'(TIMEOUT_CYC)) && !uart_valid;
  assign uart_duty_c = {hi_q, uart_byte};

  // UART frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // UART frame next state
  always_comb begin
    state_d = state_q;
    if (timeout_c) begin
      state_d = S_IDLE;
    end else if (uart_valid) begin
      case (state_q)
        S_IDLE: begin
          if (uart_byte == 8'hA5)      state_d = S_DUTY_HI;
          else if (uart_byte == 8'h5A) state_d = S_ENA;
        end
        S_DUTY_HI: state_d = S_DUTY_LO;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // UART frame decode outputs
  always_comb begin
    u_duty_req_c = 1'b0;
    u_ena_req_c  = 1'b0;
    u_ack_req_c  = 1'b0;
    u_ack_byte_c = ACK_BYTE;
    u_err_c      = 1'b0;
    if (timeout_c) begin
      u_ack_req_c  = 1'b1;
      u_ack_byte_c = NAK_BYTE;
      u_err_c      = 1'b1;
    end else if (uart_valid) begin
      case (state_q)
        S_DUTY_LO: begin
          u_ack_req_c = 1'b1;
          if (uart_duty_c <= DW'(DUTY_MAX)) begin
            u_duty_req_c = 1'b1;
          end else begin
            u_ack_byte_c = NAK_BYTE;
            u_err_c      = 1'b1;
          end
        end
        S_ENA: begin
          u_ena_req_c = 1'b1;
          u_ack_req_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign spi_ctrl_c = spi_valid && spi_word[15];
  assign spi_duty_c = spi_valid && !spi_word[15] && ({1'b0, spi_word[14:0]} <= DW'(DUTY_MAX));
  assign spi_bad_c  = spi_valid && !spi_word[15] && !spi_duty_c;
  assign spi_req_c  = spi_ctrl_c || spi_duty_c;
  assign u_defer_c  = (u_duty_req_c || u_ena_req_c) && spi_req_c;

  // Write resolution in arrival order: deferred UART, then SPI, then undeferred UART
  always_comb begin
    duty_wr_c  = 1'b0;
    duty_val_c = shadow_q;
    ena_wr_c   = 1'b0;
    ena_val_c  = pwm_enable;
    if (pend_duty_q) begin
      duty_wr_c  = 1'b1;
      duty_val_c = pend_val_q;
    end
    if (pend_ena_q) begin
      ena_wr_c  = 1'b1;
      ena_val_c = pend_val_q[0];
    end
    if (spi_duty_c) begin
      duty_wr_c  = 1'b1;
      duty_val_c = {1'b0, spi_word[14:0]};
    end
    if (spi_ctrl_c) begin
      ena_wr_c  = 1'b1;
      ena_val_c = spi_word[0];
    end
    if (u_duty_req_c && !u_defer_c) begin
      duty_wr_c  = 1'b1;
      duty_val_c = uart_duty_c;
    end
    if (u_ena_req_c && !u_defer_c) begin
      ena_wr_c  = 1'b1;
      ena_val_c = uart_byte[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q           <= '0;
      tmo_q          <= '0;
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
      pend_duty_q    <= 1'b0;
      pend_ena_q     <= 1'b0;
      pend_val_q     <= '0;
      ack_full_q     <= 1'b0;
      ack_byte_q     <= '0;
      pwm_duty       <= DW'(DUTY_RST);
      pwm_enable     <= 1'b0;
      txd_en         <= 1'b0;
      txd_data       <= '0;
      cfg_err        <= 1'b0;
    end else begin
      if (state_q == S_DUTY_HI && uart_valid) hi_q <= uart_byte;

      // Idle-gap counter, saturating at the timeout value
      if (uart_valid || state_q == S_IDLE) tmo_q <= '0;
      else if (tmo_q != TW'(TIMEOUT_CYC))  tmo_q <= tmo_q + TW'(1);

      pend_duty_q <= u_defer_c && u_duty_req_c;
      pend_ena_q  <= u_defer_c && u_ena_req_c;
      if (u_defer_c) pend_val_q <= u_duty_req_c ? uart_duty_c : DW'(uart_byte[0]);

      // Commit samples the shadow before this edge; a same-cycle write waits for the next boundary
      if (period_end && shadow_valid_q) pwm_duty <= shadow_q;
      if (duty_wr_c) begin
        shadow_q       <= duty_val_c;
        shadow_valid_q <= 1'b1;
      end else if (period_end) begin
        shadow_valid_q <= 1'b0;
      end

      if (ena_wr_c) pwm_enable <= ena_val_c;
      if (spi_bad_c || u_err_c) cfg_err <= 1'b1;

      txd_en <= 1'b0;
      if (ack_full_q && !txd_busy && !txd_en) begin
        txd_en     <= 1'b1;
        txd_data   <= ack_byte_q;
        ack_full_q <= 1'b0;
      end
      if (u_ack_req_c) begin
        ack_full_q <= 1'b1;
        ack_byte_q <= u_ack_byte_c;
      end
    end
  end

endmodule
